// File: rtl/exec_unit_pipe.sv
// Registered execute stage: valid/ready handshake, one output register,
// sticky compare flag, iterative shift-add multiply and a HALT latch.
module exec_unit_pipe #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        instr,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic              flush,
  input  logic              resume,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_wdata,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_pc_load,
  output logic              out_mem_we,
  output logic              out_halt,
  output logic              cmp_flag,
  output logic              halted
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam bit MUL_ON = (MUL_EN != 0);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [1:0]        opcode_s, rs_s, funct_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic [PC_W-1:0]   jmp_ext_s;
  logic              out_free_s, in_ready_s, accept_s;
  logic              is_mul_s, is_halt_s, is_cmp_s;
  logic              mul_start_s, mul_done_s, load_s;

  logic [DATA_W-1:0] dec_result_s, dec_wdata_s;
  logic [PC_W-1:0]   dec_pc_s;
  logic              dec_pc_load_s, dec_mem_we_s, dec_halt_s, dec_cmp_s;

  logic [DATA_W-1:0] ld_result_s, ld_wdata_s;
  logic [PC_W-1:0]   ld_pc_s;
  logic              ld_pc_load_s, ld_mem_we_s, ld_halt_s;

  logic [CNT_W-1:0]  mul_cnt_r;
  logic [DATA_W-1:0] mul_a_r, mul_b_r, mul_acc_r, mul_acc_step_s;

  logic              out_valid_r, out_pc_load_r, out_mem_we_r, out_halt_r;
  logic [DATA_W-1:0] out_result_r, out_wdata_r;
  logic [PC_W-1:0]   out_pc_r;
  logic              cmp_flag_r, halted_r;

  assign opcode_s  = instr[7:6];
  assign rs_s      = instr[5:4];
  assign funct_s   = instr[1:0];
  assign imm_ext_s = {{(DATA_W-2){1'b0}}, instr[1:0]};
  assign jmp_ext_s = {{(PC_W-6){1'b0}}, instr[5:0]};

  assign out_free_s  = !out_valid_r || out_ready;
  assign in_ready_s  = (state_r == ST_IDLE) && out_free_s && !flush && !rst;
  assign accept_s    = in_valid && in_ready_s;
  assign is_mul_s    = MUL_ON && (opcode_s == 2'b11) && (rs_s == 2'b01);
  assign is_halt_s   = (opcode_s == 2'b11) && (rs_s == 2'b00);
  assign is_cmp_s    = (opcode_s == 2'b01) && (rs_s == 2'b11);
  assign mul_start_s = accept_s && is_mul_s;
  // A finished multiply waits at count 0 until the output register can take it.
  assign mul_done_s  = (state_r == ST_MUL_BUSY) && (mul_cnt_r <= CNT_W'(1)) &&
                       out_free_s && !flush;
  assign load_s      = (accept_s && !is_mul_s) || mul_done_s;

  assign mul_acc_step_s = ((mul_cnt_r != CNT_W'(0)) && mul_b_r[0]) ?
                          (mul_acc_r + mul_a_r) : mul_acc_r;

  // Instruction decode for single-cycle ops; unset fields stay zero.
  always_comb begin
    dec_result_s  = {DATA_W{1'b0}};
    dec_wdata_s   = {DATA_W{1'b0}};
    dec_pc_s      = {PC_W{1'b0}};
    dec_pc_load_s = 1'b0;
    dec_mem_we_s  = 1'b0;
    dec_halt_s    = 1'b0;
    dec_cmp_s     = 1'b0;
    case (opcode_s)
      2'b00: begin
        case (funct_s)
          2'b00:   dec_result_s = rd1 + rd2;
          2'b01:   dec_result_s = rd1 - rd2;
          2'b10:   dec_result_s = rd1 & rd2;
          2'b11:   dec_result_s = rd1 | rd2;
          default: dec_result_s = {DATA_W{1'b0}};
        endcase
      end
      2'b01: begin
        case (rs_s)
          2'b00, 2'b01: dec_result_s = rd1 + imm_ext_s;
          2'b10: begin
            dec_result_s = rd1 + imm_ext_s;
            dec_wdata_s  = rd2;
            dec_mem_we_s = 1'b1;
          end
          2'b11: begin
            dec_cmp_s    = (rd1 == rd2);
            dec_result_s = {{(DATA_W-1){1'b0}}, dec_cmp_s};
          end
          default: dec_result_s = {DATA_W{1'b0}};
        endcase
      end
      2'b10: begin
        dec_pc_s      = jmp_ext_s;
        dec_pc_load_s = 1'b1;
      end
      2'b11: begin
        if (rs_s == 2'b00) begin
          dec_halt_s = 1'b1;
        end else begin
          dec_halt_s = 1'b0;
        end
      end
      default: dec_result_s = {DATA_W{1'b0}};
    endcase
  end

  // Select what the output register captures: multiply result or decoded op.
  always_comb begin
    ld_result_s  = dec_result_s;
    ld_wdata_s   = dec_wdata_s;
    ld_pc_s      = dec_pc_s;
    ld_pc_load_s = dec_pc_load_s;
    ld_mem_we_s  = dec_mem_we_s;
    ld_halt_s    = dec_halt_s;
    if (mul_done_s) begin
      ld_result_s  = mul_acc_step_s;
      ld_wdata_s   = {DATA_W{1'b0}};
      ld_pc_s      = {PC_W{1'b0}};
      ld_pc_load_s = 1'b0;
      ld_mem_we_s  = 1'b0;
      ld_halt_s    = 1'b0;
    end else begin
      ld_result_s  = dec_result_s;
    end
  end

  // Next-state logic for IDLE / MUL_BUSY / HALTED.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mul_start_s) begin
          state_nxt_s = ST_MUL_BUSY;
        end else if (accept_s && is_halt_s) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL_BUSY: begin
        if (flush || mul_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MUL_BUSY;
        end
      end
      ST_HALTED: begin
        if (resume) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HALTED;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and the halted indication that mirrors it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      halted_r <= (state_nxt_s == ST_HALTED);
    end
  end

  // Shift-add multiplier: one partial product per edge while count is nonzero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_cnt_r <= {CNT_W{1'b0}};
      mul_a_r   <= {DATA_W{1'b0}};
      mul_b_r   <= {DATA_W{1'b0}};
      mul_acc_r <= {DATA_W{1'b0}};
    end else if (mul_start_s) begin
      mul_cnt_r <= CNT_W'(DATA_W);
      mul_a_r   <= rd1;
      mul_b_r   <= rd2;
      mul_acc_r <= {DATA_W{1'b0}};
    end else if ((state_r == ST_MUL_BUSY) && (mul_cnt_r != CNT_W'(0))) begin
      mul_cnt_r <= mul_cnt_r - CNT_W'(1);
      mul_a_r   <= mul_a_r << 1;
      mul_b_r   <= mul_b_r >> 1;
      mul_acc_r <= mul_acc_step_s;
    end
  end

  // Output register: flush clears, load captures, consumption empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      out_valid_r   <= 1'b0;
      out_result_r  <= {DATA_W{1'b0}};
      out_wdata_r   <= {DATA_W{1'b0}};
      out_pc_r      <= {PC_W{1'b0}};
      out_pc_load_r <= 1'b0;
      out_mem_we_r  <= 1'b0;
      out_halt_r    <= 1'b0;
    end else if (load_s) begin
      out_valid_r   <= 1'b1;
      out_result_r  <= ld_result_s;
      out_wdata_r   <= ld_wdata_s;
      out_pc_r      <= ld_pc_s;
      out_pc_load_r <= ld_pc_load_s;
      out_mem_we_r  <= ld_mem_we_s;
      out_halt_r    <= ld_halt_s;
    end else if (out_ready) begin
      out_valid_r   <= 1'b0;
      out_result_r  <= {DATA_W{1'b0}};
      out_wdata_r   <= {DATA_W{1'b0}};
      out_pc_r      <= {PC_W{1'b0}};
      out_pc_load_r <= 1'b0;
      out_mem_we_r  <= 1'b0;
      out_halt_r    <= 1'b0;
    end
  end

  // Sticky compare flag, touched only when a CMP is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_flag_r <= 1'b0;
    end else if (accept_s && is_cmp_s) begin
      cmp_flag_r <= dec_cmp_s;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_result  = out_result_r;
  assign out_wdata   = out_wdata_r;
  assign out_pc      = out_pc_r;
  assign out_pc_load = out_pc_load_r;
  assign out_mem_we  = out_mem_we_r;
  assign out_halt    = out_halt_r;
  assign cmp_flag    = cmp_flag_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Bench for exec_unit_pipe: vector table plus scoreboard, with hand-written
// sequences for back-pressure, CMP, HALT/resume, MUL latency, flush and reset.
module tb_exec_unit_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, flush = 1'b0, resume = 1'b0, out_ready = 1'b1;
  logic [7:0] instr = 8'h00, rd1 = 8'h00, rd2 = 8'h00;

  logic       in_ready, out_valid, out_pc_load, out_mem_we, out_halt, cmp_flag, halted;
  logic [7:0] out_result, out_wdata, out_pc;
  logic       in_ready_n, out_valid_n, out_pc_load_n, out_mem_we_n, out_halt_n, cmp_flag_n, halted_n;
  logic [7:0] out_result_n, out_wdata_n, out_pc_n;

  exec_unit_pipe #(.DATA_W(8), .PC_W(8), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rd1(rd1), .rd2(rd2), .flush(flush), .resume(resume), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_wdata(out_wdata), .out_pc(out_pc),
    .out_pc_load(out_pc_load), .out_mem_we(out_mem_we), .out_halt(out_halt),
    .cmp_flag(cmp_flag), .halted(halted));

  exec_unit_pipe #(.DATA_W(8), .PC_W(8), .MUL_EN(0)) dut_nomul (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .instr(instr),
    .rd1(rd1), .rd2(rd2), .flush(flush), .resume(resume), .out_valid(out_valid_n),
    .out_ready(out_ready), .out_result(out_result_n), .out_wdata(out_wdata_n), .out_pc(out_pc_n),
    .out_pc_load(out_pc_load_n), .out_mem_we(out_mem_we_n), .out_halt(out_halt_n),
    .cmp_flag(cmp_flag_n), .halted(halted_n));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic [7:0] result;
    logic [7:0] wdata;
    logic [7:0] pc;
    logic       pc_load;
    logic       mem_we;
    logic       halt;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[14];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] i, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] r, input logic [7:0] w, input logic [7:0] p,
                              input logic pl, input logic we, input logic h);
    vec_t v;
    v.instr = i; v.rd1 = a; v.rd2 = b; v.result = r; v.wdata = w; v.pc = p;
    v.pc_load = pl; v.mem_we = we; v.halt = h;
    return v;
  endfunction

  // Scoreboard: every consumed result must match the oldest expectation.
  always @(negedge clk) begin : monitor
    vec_t e;
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got out_result=%0h, expected no result", out_result);
      end else begin
        e = exp_q.pop_front();
        check("out_result", out_result, e.result);
        check("out_wdata", out_wdata, e.wdata);
        check("out_pc", out_pc, e.pc);
        check1("out_pc_load", out_pc_load, e.pc_load);
        check1("out_mem_we", out_mem_we, e.mem_we);
        check1("out_halt", out_halt, e.halt);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [7:0] i, input logic [7:0] a, input logic [7:0] b,
                       input bit push, input vec_t e, input bit chk_stream, input bit exp_ov);
    bit got = 1'b0;
    instr = i; rd1 = a; rd2 = b; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (chk_stream && k == 0) begin
        check1("in_ready_stream", in_ready, 1'b1);
        check1("out_valid_stream", out_valid, exp_ov);
      end
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end else if (push) begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_in_ready"}, in_ready, 1'b0);
    check1({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_result"}, out_result, 8'h00);
    check({tag, "_out_wdata"}, out_wdata, 8'h00);
    check({tag, "_out_pc"}, out_pc, 8'h00);
    check1({tag, "_out_pc_load"}, out_pc_load, 1'b0);
    check1({tag, "_out_mem_we"}, out_mem_we, 1'b0);
    check1({tag, "_out_halt"}, out_halt, 1'b0);
    check1({tag, "_cmp_flag"}, cmp_flag, 1'b0);
    check1({tag, "_halted"}, halted, 1'b0);
  endtask

  task automatic watch_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check1("no_result_emitted", out_valid, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vec_t none;
    none = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[0]  = mk(8'h00, 8'hC8, 8'h64, 8'h2C, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // ADD
    tbl[1]  = mk(8'h01, 8'h05, 8'h07, 8'hFE, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // SUB
    tbl[2]  = mk(8'h02, 8'hF0, 8'h3C, 8'h30, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // AND
    tbl[3]  = mk(8'h03, 8'h0F, 8'h30, 8'h3F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // OR
    tbl[4]  = mk(8'h43, 8'h7F, 8'h11, 8'h82, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // ADDI
    tbl[5]  = mk(8'h56, 8'hFF, 8'h22, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // LD
    tbl[6]  = mk(8'h6E, 8'h20, 8'h5C, 8'h22, 8'h5C, 8'h00, 1'b0, 1'b1, 1'b0); // ST
    tbl[7]  = mk(8'hAA, 8'h44, 8'h55, 8'h00, 8'h00, 8'h2A, 1'b1, 1'b0, 1'b0); // J
    tbl[8]  = mk(8'hE5, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // NOP
    tbl[9]  = mk(8'hFF, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // NOP
    tbl[10] = mk(8'h70, 8'h33, 8'h34, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // CMP ne
    tbl[11] = mk(8'h00, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // ADD wrap
    tbl[12] = mk(8'h01, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0); // SUB wrap
    tbl[13] = mk(8'h80, 8'h99, 8'h99, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0); // J 0

    // Reset state
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back table with out_ready=1
    for (int i = 0; i < 14; i++)
      issue(tbl[i].instr, tbl[i].rd1, tbl[i].rd2, 1'b1, tbl[i], 1'b1, (i > 0));
    in_valid = 1'b0;
    drain();
    check1("cmp_flag_after_table", cmp_flag, 1'b0);

    // ST held under back-pressure; a following ADD waits
    out_ready = 1'b0;
    instr = 8'h63; rd1 = 8'h10; rd2 = 8'hAA; in_valid = 1'b1;
    @(negedge clk);
    check1("st_in_ready", in_ready, 1'b1);
    exp_q.push_back(mk(8'h63, 8'h10, 8'hAA, 8'h13, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0));
    @(posedge clk); #1;
    instr = 8'h00; rd1 = 8'h01; rd2 = 8'h02;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check1("st_hold_valid", out_valid, 1'b1);
      check("st_hold_result", out_result, 8'h13);
      check("st_hold_wdata", out_wdata, 8'hAA);
      check1("st_hold_mem_we", out_mem_we, 1'b1);
      check1("st_hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check1("st_release_in_ready", in_ready, 1'b1);
    exp_q.push_back(mk(8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Sticky compare flag
    issue(8'h70, 8'h5A, 8'h5A, 1'b1, mk(8'h70, 8'h5A, 8'h5A, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); check1("cmp_flag_eq", cmp_flag, 1'b1);
    @(posedge clk); #1;
    issue(8'h41, 8'h5A, 8'h00, 1'b1, mk(8'h41, 8'h5A, 8'h00, 8'h5B, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); check1("cmp_flag_sticky", cmp_flag, 1'b1);
    @(posedge clk); #1;
    issue(8'h70, 8'h5A, 8'h5B, 1'b1, mk(8'h70, 8'h5A, 8'h5B, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); check1("cmp_flag_ne", cmp_flag, 1'b0);
    drain();

    // HALT blocks a waiting ADD until resume
    issue(8'hC0, 8'h00, 8'h00, 1'b1, mk(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
    instr = 8'h00; rd1 = 8'h10; rd2 = 8'h20; in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) check1("halt_out_halt", out_halt, 1'b1);
      check1("halt_halted", halted, 1'b1);
      check1("halt_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    resume = 1'b1;
    @(negedge clk); check1("resume_cycle_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    resume = 1'b0;
    @(negedge clk);
    check1("resume_halted", halted, 1'b0);
    check1("resume_in_ready", in_ready, 1'b1);
    exp_q.push_back(mk(8'h00, 8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // MUL latency; the MUL_EN=0 instance treats it as a NOP
    issue(8'hD0, 8'h0D, 8'h0B, 1'b1, mk(8'hD0, 8'h0D, 8'h0B, 8'h8F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check1("nomul_valid", out_valid_n, 1'b1);
        check("nomul_result", out_result_n, 8'h00);
      end
      if (j < 8) begin
        check1("mul_busy_valid", out_valid, 1'b0);
        check1("mul_busy_in_ready", in_ready, 1'b0);
      end else begin
        check1("mul_done_valid", out_valid, 1'b1);
      end
    end
    drain();

    // Flush mid-MUL, then flush against a same-cycle issue
    issue(8'h70, 8'h77, 8'h77, 1'b1, mk(8'h70, 8'h77, 8'h77, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    in_valid = 1'b0;
    drain();
    issue(8'hD0, 8'h0D, 8'h0B, 1'b0, none, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk); check1("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check1("post_flush_in_ready", in_ready, 1'b1);
    check1("post_flush_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    instr = 8'h00; rd1 = 8'h01; rd2 = 8'h01; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk); check1("flush_drop_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    watch_idle(12);
    check1("flush_keeps_cmp_flag", cmp_flag, 1'b1);

    // Reset mid-MUL
    issue(8'hD0, 8'h0D, 8'h0B, 1'b0, none, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("mid_mul_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check1("post_reset_in_ready", in_ready, 1'b1);
    check1("post_reset_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    watch_idle(12);

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit_pipe.md
Name: exec_unit_pipe

Overview:
Parametrised, registered execute stage for the small out-of-order core. It replaces the purely combinational 8-bit ALU path with a valid/ready-handshaked unit that has a single output register, a sticky compare flag, an iterative multiply and a HALT latch. It sits between register read/issue and memory/writeback. The instruction encoding keeps the 8-bit ISA: opcode[7:6], rs[5:4], rt[3:2], funct/imm[1:0], jmp[5:0].

Parameters:
- DATA_W, 8, operand/result width (>=4).
- PC_W, 8, jump-target width (>=6).
- MUL_EN, 1, 1 enables the iterative MUL; 0 makes MUL a NOP.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  issue side has an instruction.
- in_ready  out  1  unit accepts this cycle.
- instr  in  8  instruction.
- rd1  in  DATA_W  rs operand.
- rd2  in  DATA_W  rt operand.
- flush  in  1  abort in-flight/held work.
- resume  in  1  single-cycle pulse that leaves HALTED.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  downstream consumes.
- out_result  out  DATA_W  ALU result or effective address.
- out_wdata  out  DATA_W  store data (ST only, else 0).
- out_pc  out  PC_W  jump target (J only, else 0).
- out_pc_load  out  1  result is a jump.
- out_mem_we  out  1  result is a store.
- out_halt  out  1  result is a HALT.
- cmp_flag  out  1  last CMP outcome (sticky).
- halted  out  1  unit is in HALTED.

Behaviour:
- Reset (async, rst=1): state=IDLE; out_valid, out_result, out_wdata, out_pc, out_pc_load, out_mem_we, out_halt, cmp_flag, halted all 0. Also in_ready=0 while rst=1.
- FSM states: IDLE, MUL_BUSY, HALTED.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. Accept = in_valid && in_ready.
- Output register:
  - Loads on the accept edge for single-cycle ops (latency 1: result visible in the cycle after accept). Sustains 1 instr/cycle while out_ready=1.
  - out_valid holds and all out_* fields stay stable while out_ready=0.
  - out_valid clears on an edge with out_ready=1 and no new load.
  - Any field not set by the op is 0.
- Arithmetic: all results are modulo 2^DATA_W. imm is zero-extended to DATA_W. jmp is zero-extended to PC_W.
- opcode 00 (R-type), by funct: 00 ADD rd1+rd2; 01 SUB rd1-rd2; 10 AND; 11 OR.
- opcode 01 (I-type), by rs field:
  - 00 ADDI: rd1+imm.
  - 01 LD: rd1+imm.
  - 10 ST: rd1+imm, out_wdata=rd2, out_mem_we=1.
  - 11 CMP: result=(rd1==rd2); cmp_flag is updated to the same value on the load edge.
- opcode 10 (J): out_pc={0,jmp}, out_pc_load=1, out_result=0.
- opcode 11, by rs field:
  - 00 HALT: result load with out_halt=1; state->HALTED, halted=1.
  - 01 MUL (MUL_EN=1): accept edge latches operands, count=DATA_W, state->MUL_BUSY. Each following edge does one shift-add step. The step edge where count reaches 0 loads out_result=low DATA_W bits of rd1*rd2 and returns to IDLE. out_valid therefore rises DATA_W edges after the accept edge. in_ready=0 throughout MUL_BUSY.
  - 01 MUL (MUL_EN=0): NOP.
  - 10/11: NOP, i.e. out_valid=1 with all fields 0.
- MUL completes only if the output register is free or being consumed that edge. Otherwise the unit stalls in MUL_BUSY with count=0 until it is free.
- HALTED: in_ready=0. A resume pulse returns the unit to IDLE and clears halted. The pending HALT result still drains normally via out_ready. resume outside HALTED, or on the HALT accept edge itself, is ignored.
- flush=1 at an edge:
  - out_valid->0 and the output fields are cleared.
  - Any MUL is aborted: MUL_BUSY->IDLE.
  - A same-cycle accept is dropped, because in_ready is forced 0.
  - halted and cmp_flag are unaffected; HALTED stays HALTED.
- Reset mid-MUL or in HALTED: immediate return to the reset state, with no result emitted.
- rd1/rd2/instr are sampled only on the accept edge and may change freely afterwards.

Test Plan:
- Back-to-back ADD 200+100, SUB 5-7, AND F0&3C, OR 0F|30 with out_ready=1 -> results 2C, FE, 30, 3F on 4 consecutive cycles, with in_ready held at 1.
- ST rd1=10, imm=3, rd2=AA, with out_ready=0 for 3 cycles -> out_result=13, out_wdata=AA, out_mem_we=1 held stable; in_ready=0 until the cycle out_ready=1.
- CMP 5A vs 5A, then ADDI, then CMP 5A vs 5B -> results 1, -, 0; cmp_flag is 1 through the ADDI and drops to 0 on the second CMP load edge.
- MUL 0D*0B (DATA_W=8) -> out_valid rises exactly 8 edges after accept with out_result=8F; in_ready=0 during those 8 cycles. The same MUL with MUL_EN=0 -> NOP result 0 after 1 cycle.
- HALT then in_valid held high with ADD -> out_halt=1, halted=1, ADD not accepted. resume pulse -> halted=0 and ADD accepted the next cycle.
- flush 3 cycles into a MUL, and separately rst asserted mid-MUL -> no result emitted, in_ready=1 the following cycle; after rst, every output is 0.
